dma_burst_engine: RTL and testbench
===================================

Name: dma_burst_engine

Overview:
- Parametrised successor to the single-channel CI-controlled DMA.
- Moves a block of 32-bit words between a local dual-port SRAM (controller side) and the shared address/data bus.
- Configured and polled through custom-instruction (CI) register accesses.
- Splits a block into bursts of programmable length and tracks residual count, error and completion status.
- Supports aborts. Unlike the previous generation, it also handles partial final bursts, slave-terminated bursts and byte addressing.

Parameters:
- CUSTOM_ID, 8'h00, CI number this block responds to.
- MEM_ADDR_W, 9, local SRAM word-address width.
- BLOCK_W, 10, block-size counter width (words).
- BURST_W, 8, burst-length field width (beats minus one).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ci_start  in  1  CI strobe.
- ci_n  in  8  CI number.
- value_a  in  32  CI operand A: [12:10] register select, [9] write enable.
- value_b  in  32  CI operand B: write data.
- ci_done  out  1  CI completion, one-cycle pulse.
- ci_result  out  32  CI read data, valid with ci_done, else 0.
- request_bus  out  1  bus request.
- bus_granted  in  1  bus grant.
- begin_transaction_out  out  1  burst start.
- address_data_out  out  32  address during begin, write data during beats, else 0.
- byte_enables_out  out  4  4'hF during begin, else 0.
- burst_size_out  out  8  beats-1, valid during begin, else 0.
- read_n_write_out  out  1  1 = bus read, valid during begin.
- data_valid_out  out  1  write beat valid.
- end_transaction_out  out  1  master end of burst.
- address_data_in  in  32  read data.
- data_valid_in  in  1  read beat valid.
- end_transaction_in  in  1  slave end of burst.
- busy_in  in  1  slave stall.
- error_in  in  1  bus error.
- mem_addr  out  MEM_ADDR_W  SRAM word address.
- mem_wdata  out  32  SRAM write data.
- mem_we  out  1  SRAM write strobe.
- mem_rdata  in  32  SRAM read data, 1-cycle latency.

Behaviour:

Reset:
- All registers, counters and the FSM clear.
- All outputs are 0.
- Reset mid-transfer drops the bus immediately, with no end_transaction_out.

CI accesses:
- An access is ci_start && ci_n==CUSTOM_ID. It completes in the next cycle: ci_done=1 with ci_result.
- sel1 bus start: 32-bit byte address; bits[1:0] are forced to 0.
- sel2 mem start: MEM_ADDR_W bits.
- sel3 block size in words: BLOCK_W bits; 0 means nothing to transfer.
- sel4 burst size: BURST_W bits (beats-1).
- sel5 write = control: bit0 go, bit1 dir (1 = SRAM->bus, 0 = bus->SRAM), bit2 abort.
- sel5 read = status: {remaining[BLOCK_W-1:0] at [31:16], done[2], error[1], busy[0]}.
- Reads of sel1-4 return the zero-extended register value.
- sel0, sel6, sel7: no effect, read 0, still ack.
- Writes to sel1-4 while busy are ignored but acked.
- go clears done and error.
- go with block size 0 sets done the next cycle without requesting the bus.

FSM states: IDLE, REQ, BEGIN, XFER, END.
- IDLE: on go, load the word pointer, remaining=block, busy=1 -> REQ.
- REQ: request_bus=1 until bus_granted -> BEGIN.
- BEGIN (1 cycle):
  - begin_transaction_out=1; address_data_out = bus start + 4*words done.
  - burst_size_out = min(burst+1, remaining)-1.
  - read_n_write_out = ~dir.
  - When dir=1, mem_addr presents the first word.
  - -> XFER.
- XFER, dir=0:
  - Each data_valid_in writes address_data_in to mem_addr = mem start + words done (mem_we=1), then increments words done and decrements remaining.
  - Burst ends after burst_size_out+1 beats or on end_transaction_in.
- XFER, dir=1:
  - data_valid_out=1 with the current SRAM word.
  - A beat is consumed on a cycle where busy_in=0; the next word is prefetched so that consecutive beats carry no bubble.
  - After the last beat -> END.
- END: end_transaction_out=1 for exactly 1 cycle (dir=1 only). Then, if remaining>0 -> REQ, else done=1, busy=0 -> IDLE.
  - dir=0: the master does not assert end; XFER goes straight to the remaining check.
- error_in in BEGIN or XFER: the current beat is not counted; error=1, busy=0, request released -> IDLE. remaining keeps its value.
- Abort while busy: finish the current beat, assert end_transaction_out if in dir=1 XFER, then go to IDLE with done=0.
- SRAM address wraps modulo 2^MEM_ADDR_W. The bus address increments 32-bit modulo.
- A CI status read is serviced in any state.

Test Plan:
- Config readback: write sel1=0x1000, sel2=5, sel3=7, sel4=3 -> each read returns the same value; ci_done is one cycle after each strobe.
- Bus->SRAM, block 7, burst 3 (4 beats):
  - two bursts: begin addresses 0x1000 and 0x1010, burst_size_out 3 then 2.
  - SRAM words 5..11 hold the slave data.
  - status = 0x0000_0004.
- SRAM->bus, block 4, burst 7, busy_in high on beat 2 for 3 cycles -> data_valid_out is held with unchanged data; one begin, burst_size_out=3, one end pulse.
- Slave end_transaction_in after 2 of 4 beats, block 4 -> a second request follows with begin address +8 and burst_size_out=1.
- error_in on beat 3 of block 8 -> status error=1, busy=0, remaining=6; the next go clears error.
- Block size 0 -> done with no request_bus. Reset asserted mid-burst -> all outputs are 0 the next cycle.

Source files
------------

// File: rtl/dma_burst_engine.sv
// rtl/dma_burst_engine.sv - CI-programmed burst DMA between local SRAM and the shared bus
// Splits a block into bursts and tracks residual count, error, done and abort.
module dma_burst_engine #(
  parameter logic [7:0] CUSTOM_ID  = 8'h00,
  parameter int         MEM_ADDR_W = 9,
  parameter int         BLOCK_W    = 10,
  parameter int         BURST_W    = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ci_start,
  input  logic [7:0]            ci_n,
  input  logic [31:0]           value_a,
  input  logic [31:0]           value_b,
  output logic                  ci_done,
  output logic [31:0]           ci_result,
  output logic                  request_bus,
  input  logic                  bus_granted,
  output logic                  begin_transaction_out,
  output logic [31:0]           address_data_out,
  output logic [3:0]            byte_enables_out,
  output logic [7:0]            burst_size_out,
  output logic                  read_n_write_out,
  output logic                  data_valid_out,
  output logic                  end_transaction_out,
  input  logic [31:0]           address_data_in,
  input  logic                  data_valid_in,
  input  logic                  end_transaction_in,
  input  logic                  busy_in,
  input  logic                  error_in,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_we,
  input  logic [31:0]           mem_rdata
);
  localparam int CW = (BURST_W >= BLOCK_W) ? BURST_W + 1 : BLOCK_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_BEGIN = 3'd2;
  localparam logic [2:0] S_XFER  = 3'd3;
  localparam logic [2:0] S_END   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [31:0]           bus_start_q, bus_start_d;
  logic [MEM_ADDR_W-1:0] mem_start_q, mem_start_d;
  logic [BLOCK_W-1:0]    block_q, block_d;
  logic [BLOCK_W-1:0]    remaining_q, remaining_d;
  logic [BLOCK_W-1:0]    words_q, words_d;
  logic [BURST_W-1:0]    burst_q, burst_d;
  logic [CW-1:0]         beats_q, beats_d;
  logic                  dir_q, dir_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  abort_q, abort_d;
  logic                  ci_done_q, ci_done_d;
  logic [31:0]           ci_result_q, ci_result_d;

  logic                  access;
  logic                  wr;
  logic [2:0]            sel;
  logic                  busy;
  logic [CW-1:0]         len;
  logic                  beat;
  logic                  last;
  logic                  burst_over;
  logic [BLOCK_W-1:0]    rem_after;
  logic [MEM_ADDR_W-1:0] mem_ptr;
  logic [31:0]           bus_ptr;
  logic                  unused_ok;

  assign access     = ci_start && (ci_n == CUSTOM_ID);
  assign wr         = value_a[9];
  assign sel        = value_a[12:10];
  assign busy       = (state_q != S_IDLE);
  assign len        = ((CW'(burst_q) + CW'(1)) < CW'(remaining_q)) ? CW'(burst_q) + CW'(1)
                                                                   : CW'(remaining_q);
  // A dir=1 beat is a cycle the slave does not stall; dir=0 beats come from the slave.
  assign beat       = (state_q == S_XFER) && !error_in && (dir_q ? !busy_in : data_valid_in);
  assign last       = (beats_q == CW'(1));
  assign burst_over = (beat && last) || end_transaction_in;
  assign rem_after  = beat ? remaining_q - BLOCK_W'(1) : remaining_q;
  assign mem_ptr    = mem_start_q + MEM_ADDR_W'(words_q);
  assign bus_ptr    = bus_start_q + (32'(words_q) << 2);
  assign unused_ok  = ^{value_a[31:13], value_a[8:0]};

  assign ci_done    = ci_done_q;
  assign ci_result  = ci_result_q;

  always_comb begin
    request_bus           = 1'b0;
    begin_transaction_out = 1'b0;
    address_data_out      = 32'd0;
    byte_enables_out      = 4'h0;
    burst_size_out        = 8'd0;
    read_n_write_out      = 1'b0;
    data_valid_out        = 1'b0;
    end_transaction_out   = 1'b0;
    mem_addr              = '0;
    mem_wdata             = 32'd0;
    mem_we                = 1'b0;
    case (state_q)
      S_REQ: request_bus = 1'b1;
      S_BEGIN: begin
        request_bus           = 1'b1;
        begin_transaction_out = 1'b1;
        address_data_out      = bus_ptr;
        byte_enables_out      = 4'hF;
        burst_size_out        = 8'(len - CW'(1));
        read_n_write_out      = ~dir_q;
        if (dir_q) mem_addr = mem_ptr;
      end
      S_XFER: begin
        request_bus = 1'b1;
        if (dir_q) begin
          data_valid_out   = 1'b1;
          address_data_out = mem_rdata;
          // Prefetch the following word when this beat is taken so stalls never bubble.
          mem_addr         = beat ? mem_ptr + MEM_ADDR_W'(1) : mem_ptr;
        end else if (beat) begin
          mem_we    = 1'b1;
          mem_addr  = mem_ptr;
          mem_wdata = address_data_in;
        end
      end
      S_END: begin
        request_bus         = 1'b1;
        end_transaction_out = dir_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bus_start_d = bus_start_q;
    mem_start_d = mem_start_q;
    block_d     = block_q;
    remaining_d = remaining_q;
    words_d     = words_q;
    burst_d     = burst_q;
    beats_d     = beats_q;
    dir_d       = dir_q;
    done_d      = done_q;
    error_d     = error_q;
    abort_d     = abort_q;
    ci_done_d   = access;
    ci_result_d = 32'd0;

    if (access) begin
      if (wr) begin
        case (sel)
          3'd1: if (!busy) bus_start_d = {value_b[31:2], 2'b00};
          3'd2: if (!busy) mem_start_d = value_b[MEM_ADDR_W-1:0];
          3'd3: if (!busy) block_d = value_b[BLOCK_W-1:0];
          3'd4: if (!busy) burst_d = value_b[BURST_W-1:0];
          3'd5: begin
            if (!busy && value_b[0]) begin
              dir_d       = value_b[1];
              error_d     = 1'b0;
              words_d     = '0;
              remaining_d = block_q;
              done_d      = (block_q == '0);
              if (block_q != '0) state_d = S_REQ;
            end else if (busy && value_b[2]) begin
              abort_d = 1'b1;
            end
          end
          default: ;
        endcase
      end else begin
        case (sel)
          3'd1: ci_result_d = bus_start_q;
          3'd2: ci_result_d = 32'(mem_start_q);
          3'd3: ci_result_d = 32'(block_q);
          3'd4: ci_result_d = 32'(burst_q);
          3'd5: ci_result_d = {16'(remaining_q), 13'd0, done_q, error_q, busy};
          default: ;
        endcase
      end
    end

    case (state_q)
      S_IDLE: abort_d = 1'b0;
      S_REQ: begin
        if (abort_q) begin
          abort_d = 1'b0;
          state_d = S_IDLE;
        end else if (bus_granted) begin
          state_d = S_BEGIN;
        end
      end
      S_BEGIN: begin
        if (error_in) begin
          error_d = 1'b1;
          abort_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          beats_d = len;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (error_in) begin
          error_d = 1'b1;
          abort_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          if (beat) begin
            words_d     = words_q + BLOCK_W'(1);
            remaining_d = rem_after;
            beats_d     = beats_q - CW'(1);
          end
          if (dir_q && beat && (last || abort_q)) begin
            state_d = S_END;
          end else if ((dir_q && end_transaction_in) || (!dir_q && (burst_over || abort_q))) begin
            abort_d = 1'b0;
            done_d  = !abort_q && (rem_after == '0);
            state_d = (abort_q || rem_after == '0) ? S_IDLE : S_REQ;
          end
        end
      end
      S_END: begin
        abort_d = 1'b0;
        done_d  = !abort_q && (remaining_q == '0);
        state_d = (abort_q || remaining_q == '0) ? S_IDLE : S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bus_start_q <= '0;
      mem_start_q <= '0;
      block_q     <= '0;
      remaining_q <= '0;
      words_q     <= '0;
      burst_q     <= '0;
      beats_q     <= '0;
      dir_q       <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      abort_q     <= 1'b0;
      ci_done_q   <= 1'b0;
      ci_result_q <= '0;
    end else begin
      state_q     <= state_d;
      bus_start_q <= bus_start_d;
      mem_start_q <= mem_start_d;
      block_q     <= block_d;
      remaining_q <= remaining_d;
      words_q     <= words_d;
      burst_q     <= burst_d;
      beats_q     <= beats_d;
      dir_q       <= dir_d;
      done_q      <= done_d;
      error_q     <= error_d;
      abort_q     <= abort_d;
      ci_done_q   <= ci_done_d;
      ci_result_q <= ci_result_d;
    end
  end

endmodule

// File: tb/tb_dma_burst_engine.sv
// tb/tb_dma_burst_engine.sv - directed self-checking bench for dma_burst_engine
module tb_dma_burst_engine;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ci_start = 1'b0;
  logic [7:0]  ci_n = 8'h00;
  logic [31:0] value_a = 32'd0;
  logic [31:0] value_b = 32'd0;
  logic        ci_done;
  logic [31:0] ci_result;
  logic        request_bus;
  logic        bus_granted = 1'b0;
  logic        begin_transaction_out;
  logic [31:0] address_data_out;
  logic [3:0]  byte_enables_out;
  logic [7:0]  burst_size_out;
  logic        read_n_write_out;
  logic        data_valid_out;
  logic        end_transaction_out;
  logic [31:0] address_data_in = 32'd0;
  logic        data_valid_in = 1'b0;
  logic        end_transaction_in = 1'b0;
  logic        busy_in = 1'b0;
  logic        error_in = 1'b0;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic [31:0] sram [0:511];

  int checks = 0;
  int failures = 0;
  logic [31:0] r;
  bit saw_req;
  bit busy_pat [0:6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  int idx_pat  [0:6] = '{0, 1, 1, 1, 1, 2, 3};

  dma_burst_engine dut (
    .clock(clock), .reset(reset), .ci_start(ci_start), .ci_n(ci_n),
    .value_a(value_a), .value_b(value_b), .ci_done(ci_done), .ci_result(ci_result),
    .request_bus(request_bus), .bus_granted(bus_granted),
    .begin_transaction_out(begin_transaction_out), .address_data_out(address_data_out),
    .byte_enables_out(byte_enables_out), .burst_size_out(burst_size_out),
    .read_n_write_out(read_n_write_out), .data_valid_out(data_valid_out),
    .end_transaction_out(end_transaction_out), .address_data_in(address_data_in),
    .data_valid_in(data_valid_in), .end_transaction_in(end_transaction_in),
    .busy_in(busy_in), .error_in(error_in), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    mem_rdata <= sram[mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {request_bus, begin_transaction_out, data_valid_out, end_transaction_out,
                          mem_we, ci_done, read_n_write_out, byte_enables_out, burst_size_out}, 64'd0);
    check({tag, "_data"}, {address_data_out, mem_wdata}, 64'd0);
    check({tag, "_addr"}, {mem_addr, ci_result}, 64'd0);
  endtask

  task automatic ci(input logic [2:0] sel, input bit we, input logic [31:0] data,
                    output logic [31:0] res);
    ci_start = 1'b1;
    ci_n     = 8'h00;
    value_a  = {19'd0, sel, we, 9'd0};
    value_b  = data;
    @(negedge clock);
    ci_start = 1'b0;
    value_a  = 32'd0;
    value_b  = 32'd0;
    #1;
    check("ci_done", ci_done, 1);
    res = ci_result;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!request_bus && n < 40) begin
      @(negedge clock);
      #1;
      n++;
    end
    check(tag, request_bus, 1);
  endtask

  // Slave side of a bus->SRAM burst: grant, check the begin phase, then feed beats.
  task automatic slave_burst(input logic [31:0] addr, input logic [7:0] size, input int nbeats,
                             input bit slave_end, input logic [31:0] d0, input logic [8:0] m0);
    wait_req("req");
    bus_granted = 1'b1;
    @(negedge clock);
    bus_granted = 1'b0;
    #1;
    check("begin_ctl", {begin_transaction_out, read_n_write_out, byte_enables_out}, 6'b11_1111);
    check("begin_addr", address_data_out, addr);
    check("burst_size", burst_size_out, size);
    for (int i = 0; i < nbeats; i++) begin
      @(negedge clock);
      data_valid_in      = 1'b1;
      address_data_in    = d0 + 32'(i);
      end_transaction_in = slave_end && (i == nbeats - 1);
      #1;
      check("beat_we", {mem_we, mem_addr, mem_wdata}, {1'b1, m0 + 9'(i), d0 + 32'(i)});
    end
    @(negedge clock);
    data_valid_in      = 1'b0;
    end_transaction_in = 1'b0;
    address_data_in    = 32'd0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    #1;
    check_quiet("reset");
    reset = 1'b0;
    @(negedge clock);

    // configuration readback, ci_done pulse and foreign CI number
    ci(3'd1, 1'b1, 32'h0000_1003, r);
    ci(3'd2, 1'b1, 32'd5, r);
    ci(3'd3, 1'b1, 32'd7, r);
    ci(3'd4, 1'b1, 32'd3, r);
    ci(3'd1, 1'b0, 32'd0, r); check("rd_bus_start", r, 32'h0000_1000);
    ci(3'd2, 1'b0, 32'd0, r); check("rd_mem_start", r, 32'd5);
    ci(3'd3, 1'b0, 32'd0, r); check("rd_block", r, 32'd7);
    ci(3'd4, 1'b0, 32'd0, r); check("rd_burst", r, 32'd3);
    ci(3'd6, 1'b0, 32'd0, r); check("rd_sel6", r, 32'd0);
    @(negedge clock); #1;
    check("ci_done_pulse", ci_done, 0);
    ci_start = 1'b1; ci_n = 8'h01; value_a = {19'd0, 3'd1, 1'b0, 9'd0};
    @(negedge clock);
    ci_start = 1'b0; ci_n = 8'h00; value_a = 32'd0;
    #1;
    check("foreign_ci", ci_done, 0);

    // bus->SRAM, block 7, burst 4 beats: 4 + 3
    ci(3'd5, 1'b1, 32'd1, r);
    slave_burst(32'h0000_1000, 8'd3, 4, 1'b0, 32'hA000_0000, 9'd5);
    slave_burst(32'h0000_1010, 8'd2, 3, 1'b0, 32'hA000_0004, 9'd9);
    ci(3'd5, 1'b0, 32'd0, r); check("status_rd", r, 32'h0000_0004);
    for (int i = 0; i < 7; i++) check("sram_rd", sram[5 + i], 32'hA000_0000 + 32'(i));

    // SRAM->bus, block 4 from word 5, burst 8, slave stalls beat 2 for 3 cycles
    ci(3'd1, 1'b1, 32'h0000_2000, r);
    ci(3'd3, 1'b1, 32'd4, r);
    ci(3'd4, 1'b1, 32'd7, r);
    ci(3'd5, 1'b1, 32'd3, r);
    wait_req("req_wr");
    bus_granted = 1'b1;
    @(negedge clock);
    bus_granted = 1'b0;
    #1;
    check("wr_begin_ctl", {begin_transaction_out, read_n_write_out, byte_enables_out}, 6'b10_1111);
    check("wr_begin_addr", address_data_out, 32'h0000_2000);
    check("wr_burst_size", burst_size_out, 8'd3);
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      busy_in = busy_pat[c];
      #1;
      check("wr_beat", {data_valid_out, begin_transaction_out, end_transaction_out, address_data_out},
            {3'b100, 32'hA000_0000 + 32'(idx_pat[c])});
    end
    @(negedge clock);
    busy_in = 1'b0;
    #1;
    check("wr_end", {end_transaction_out, data_valid_out, request_bus}, 3'b101);
    @(negedge clock); #1;
    check("wr_idle", {end_transaction_out, begin_transaction_out, request_bus}, 3'b000);
    ci(3'd5, 1'b0, 32'd0, r); check("wr_status", r, 32'h0000_0004);

    // slave ends the first burst after 2 of 4 beats
    ci(3'd1, 1'b1, 32'h0000_3000, r);
    ci(3'd2, 1'b1, 32'd40, r);
    ci(3'd4, 1'b1, 32'd3, r);
    ci(3'd5, 1'b1, 32'd1, r);
    slave_burst(32'h0000_3000, 8'd3, 2, 1'b1, 32'hC000_0000, 9'd40);
    slave_burst(32'h0000_3008, 8'd1, 2, 1'b0, 32'hC000_0002, 9'd42);
    ci(3'd5, 1'b0, 32'd0, r); check("send_status", r, 32'h0000_0004);
    check("send_sram", sram[43], 32'hC000_0003);

    // bus error on beat 3 of block 8, then go clears it and abort ends the retry
    ci(3'd2, 1'b1, 32'd60, r);
    ci(3'd3, 1'b1, 32'd8, r);
    ci(3'd4, 1'b1, 32'd7, r);
    ci(3'd5, 1'b1, 32'd1, r);
    wait_req("req_err");
    bus_granted = 1'b1;
    @(negedge clock);
    bus_granted = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      data_valid_in   = 1'b1;
      address_data_in = 32'(i);
      error_in        = (i == 2);
      #1;
      if (i == 2) check("err_no_we", mem_we, 0);
    end
    @(negedge clock);
    data_valid_in = 1'b0;
    error_in      = 1'b0;
    #1;
    check("err_req_drop", request_bus, 0);
    ci(3'd5, 1'b0, 32'd0, r); check("err_status", r, 32'h0006_0002);
    ci(3'd5, 1'b1, 32'd1, r);
    ci(3'd5, 1'b0, 32'd0, r); check("rego_status", r, 32'h0008_0001);
    ci(3'd5, 1'b1, 32'd4, r);
    @(negedge clock);
    ci(3'd5, 1'b0, 32'd0, r); check("abort_status", r, 32'h0008_0000);

    // block size 0: done without touching the bus
    ci(3'd3, 1'b1, 32'd0, r);
    ci(3'd5, 1'b1, 32'd1, r);
    saw_req = request_bus;
    ci(3'd5, 1'b0, 32'd0, r); check("zero_status", r, 32'h0000_0004);
    for (int i = 0; i < 4; i++) begin
      saw_req |= request_bus;
      @(negedge clock); #1;
    end
    check("zero_no_req", saw_req, 0);

    // reset in the middle of a stalled SRAM->bus burst
    ci(3'd3, 1'b1, 32'd4, r);
    ci(3'd5, 1'b1, 32'd3, r);
    wait_req("req_rst");
    bus_granted = 1'b1;
    @(negedge clock);
    bus_granted = 1'b0;
    busy_in     = 1'b1;
    @(negedge clock); #1;
    check("rst_midburst", data_valid_out, 1);
    reset = 1'b1;
    @(negedge clock); #1;
    check_quiet("rst_drop");
    reset   = 1'b0;
    busy_in = 1'b0;
    @(negedge clock);
    ci(3'd5, 1'b0, 32'd0, r); check("rst_status", r, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
